hdmi_timing_measure: RTL

- Consumes the decoded sync and data-valid stream in the TMDS pixel clock domain, alongside the framebuffer writer.
- Measures the incoming video geometry every frame: total and active pixels per line, hsync width, total and active lines.
- Publishes the results with a per-frame strobe and a "stable" flag, so framebuffer windowing and the UART reporting path can trust the mode.

---
 rtl/hdmi_timing_pkg.sv | 28 ++
 rtl/hdmi_timing_measure_sync_edge.sv | 22 ++
 rtl/hdmi_timing_measure.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/hdmi_timing_pkg.sv
// Shared definitions for the HDMI input timing measurement block.
package hdmi_timing_pkg;

  // Default width of every pixel/line counter and measurement field
  localparam int DEF_CNT_WIDTH = 12;

  // Width of the consecutive-matching-frame counter (STABLE_FRAMES is 1..15)
  localparam int MATCH_W = 4;

  // Measurement FSM
  typedef enum logic [1:0] {
    SEARCH  = 2'd0,
    MEASURE = 2'd1,
    RUN     = 2'd2
  } state_t;

  // Measurement record at the default width, MSB first
  typedef struct packed {
    logic [DEF_CNT_WIDTH-1:0] h_total;
    logic [DEF_CNT_WIDTH-1:0] h_active;
    logic [DEF_CNT_WIDTH-1:0] h_sync;
    logic [DEF_CNT_WIDTH-1:0] v_total;
    logic [DEF_CNT_WIDTH-1:0] v_active;
  } meas_t;

  localparam int MEAS_W = $bits(meas_t);

endpackage

// File: rtl/hdmi_timing_measure_sync_edge.sv
// Valid-gated sync sampler producing fall/rise pulses for one sync input.
module sync_edge (
  input  logic clk,
  input  logic reset,
  input  logic valid,
  input  logic sig,
  output logic fall,
  output logic rise
);

  logic sig_q;

  // Previous sample only moves on valid cycles, so gaps in lock never fake an edge
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)     sig_q <= 1'b1;
    else if (valid) sig_q <= sig;
  end

  assign fall = valid & ~sig &  sig_q;
  assign rise = valid &  sig & ~sig_q;

endmodule

// File: rtl/hdmi_timing_measure.sv
// Per-frame HDMI geometry measurement with stability tracking.
module hdmi_timing_measure
  import hdmi_timing_pkg::*;
#(
  parameter int CNT_WIDTH     = DEF_CNT_WIDTH,
  parameter int STABLE_FRAMES = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 valid,
  input  logic                 hsync,
  input  logic                 vsync,
  input  logic                 data_valid,
  output logic [CNT_WIDTH-1:0] h_total,
  output logic [CNT_WIDTH-1:0] h_active,
  output logic [CNT_WIDTH-1:0] h_sync,
  output logic [CNT_WIDTH-1:0] v_total,
  output logic [CNT_WIDTH-1:0] v_active,
  output logic                 frame_strobe,
  output logic                 stable,
  output logic                 overflow
);

  localparam logic [CNT_WIDTH-1:0] CMAX      = '1;
  localparam logic [CNT_WIDTH-1:0] ONE       = CNT_WIDTH'(1);
  localparam logic [MATCH_W-1:0]   MC_MAX    = '1;
  localparam logic [MATCH_W-1:0]   MC_ONE    = MATCH_W'(1);
  localparam logic [MATCH_W-1:0]   MC_STABLE = MATCH_W'(STABLE_FRAMES);

  logic hfall, hrise, vfall;
  logic vrise_unused;  // vsync width is not part of the measured geometry

  logic [CNT_WIDTH-1:0] hcnt, hlow, acnt, h_line, hs_cap, amax, vact, lcnt;
  logic [CNT_WIDTH-1:0] h_line_n, hs_cap_n, amax_n, vact_n;
  logic [5*CNT_WIDTH-1:0] meas_n, prev_meas;
  logic [MATCH_W-1:0]   match_cnt, mc_n;
  logic                 ovf_evt;
  state_t               state;

  sync_edge u_hs (
    .clk   (clk),
    .reset (reset),
    .valid (valid),
    .sig   (hsync),
    .fall  (hfall),
    .rise  (hrise)
  );

  sync_edge u_vs (
    .clk   (clk),
    .reset (reset),
    .valid (valid),
    .sig   (vsync),
    .fall  (vfall),
    .rise  (vrise_unused)
  );

  // Values as they stand after this cycle's line-end processing, so a vfall
  // coincident with hfall captures the line that just closed.
  assign h_line_n = hfall ? hcnt : h_line;
  assign hs_cap_n = hrise ? hlow : hs_cap;
  assign amax_n   = (hfall && (acnt > amax)) ? acnt : amax;
  assign vact_n   = (hfall && (acnt != '0) && (vact != CMAX)) ? vact + ONE : vact;
  assign meas_n   = {h_line_n, amax_n, hs_cap_n, lcnt, vact_n};

  // Any counter pinned at full scale while it should still be counting
  assign ovf_evt = valid & ((~hfall & (hcnt == CMAX)) |
                            (~hsync & ~hfall & (hlow == CMAX)) |
                            (data_valid & ~hfall & (acnt == CMAX)) |
                            (hfall & ~vfall & (lcnt == CMAX)));

  // match_cnt starts at 1 for the measured frame, so each identical frame adds one
  assign mc_n = (meas_n != prev_meas) ? MC_ONE :
                (match_cnt == MC_MAX) ? match_cnt : match_cnt + MC_ONE;

  // Line and frame counters; all frozen while valid is low
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hcnt   <= '0;
      hlow   <= '0;
      acnt   <= '0;
      h_line <= '0;
      hs_cap <= '0;
      amax   <= '0;
      vact   <= '0;
      lcnt   <= '0;
    end else if (valid) begin
      if (hfall) begin
        hcnt   <= ONE;
        h_line <= hcnt;
      end else if (hcnt != CMAX) begin
        hcnt <= hcnt + ONE;
      end
      // hfall cycle is itself the first low clock of the pulse
      if (hfall)                          hlow <= ONE;
      else if (!hsync && (hlow != CMAX))  hlow <= hlow + ONE;
      if (hrise) hs_cap <= hlow;
      if (hfall)                             acnt <= data_valid ? ONE : '0;
      else if (data_valid && (acnt != CMAX)) acnt <= acnt + ONE;
      if (vfall) begin
        amax <= '0;
        vact <= '0;
        lcnt <= ONE;
      end else if (hfall) begin
        amax <= amax_n;
        vact <= vact_n;
        if (lcnt != CMAX) lcnt <= lcnt + ONE;
      end
    end
  end

  // Session FSM: publish, stability tracking and sticky overflow
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= SEARCH;
      h_total      <= '0;
      h_active     <= '0;
      h_sync       <= '0;
      v_total      <= '0;
      v_active     <= '0;
      frame_strobe <= 1'b0;
      stable       <= 1'b0;
      overflow     <= 1'b0;
      match_cnt    <= '0;
      prev_meas    <= '0;
    end else begin
      frame_strobe <= 1'b0;
      if (!valid) begin
        // Lost lock: restart the session, outputs keep their last values
        state    <= SEARCH;
        stable   <= 1'b0;
        overflow <= 1'b0;
      end else begin
        if (ovf_evt)             overflow <= 1'b1;
        if (ovf_evt || overflow) stable   <= 1'b0;
        case (state)
          SEARCH: begin
            if (vfall) state <= MEASURE;
          end
          MEASURE: begin
            if (vfall) begin
              prev_meas <= meas_n;
              match_cnt <= MC_ONE;
              state     <= RUN;
            end
          end
          RUN: begin
            if (vfall) begin
              {h_total, h_active, h_sync, v_total, v_active} <= meas_n;
              prev_meas    <= meas_n;
              match_cnt    <= mc_n;
              frame_strobe <= 1'b1;
              stable       <= (mc_n >= MC_STABLE) && !(overflow || ovf_evt);
            end
          end
          default: state <= SEARCH;
        endcase
      end
    end
  end

endmodule
